// File: rtl/decode_issue_controller.sv
// IF/ID pipeline register with load-use bubble insertion, branch squash and
// saturating stall/flush counters for CPI reporting.
module decode_issue_controller #(
  parameter int INSTR_LEN = 32,
  parameter int REG_ADDR  = 5,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fetch_valid,
  input  logic [INSTR_LEN-1:0] fetch_instruction,
  output logic                 fetch_ready,
  output logic                 issue_valid,
  output logic [INSTR_LEN-1:0] issue_instruction,
  input  logic                 issue_ready,
  input  logic                 branch_flush,
  output logic [1:0]           state,
  output logic [CNT_W-1:0]     stall_count,
  output logic [CNT_W-1:0]     flush_count
);

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    FULL  = 2'b01,
    STALL = 2'b10
  } state_t;

  localparam logic [REG_ADDR-1:0] XZR = {REG_ADDR{1'b1}};

  state_t               state_reg, state_next;
  logic                 held_valid_reg, held_valid_next;
  logic [INSTR_LEN-1:0] held_instr_reg, held_instr_next;
  logic                 last_load_valid_reg, last_load_valid_next;
  logic [REG_ADDR-1:0]  last_load_rt_reg, last_load_rt_next;
  logic [CNT_W-1:0]     stall_count_reg, stall_count_next;
  logic [CNT_W-1:0]     flush_count_reg, flush_count_next;

  logic [10:0]         op11;
  logic                is_ldur, is_stur, is_rtype, is_cbz;
  logic [REG_ADDR-1:0] rn, rm, rt;
  logic                use_rn, use_rb;
  logic [REG_ADDR-1:0] rb;
  logic                hazard, fire;

  assign op11     = held_instr_reg[31:21];
  assign is_ldur  = (op11 == 11'b11111000010);
  assign is_stur  = (op11 == 11'b11111000000);
  assign is_rtype = (op11 == 11'b10001011000) || (op11 == 11'b11001011000) ||
                    (op11 == 11'b10001010000) || (op11 == 11'b10101010000);
  assign is_cbz   = (held_instr_reg[31:24] == 8'b10110100);

  assign rn = held_instr_reg[5 +: REG_ADDR];
  assign rm = held_instr_reg[16 +: REG_ADDR];
  assign rt = held_instr_reg[0 +: REG_ADDR];

  // Second source is Rm for R-type, Rt for stores and CBZ.
  assign use_rn = is_rtype | is_ldur | is_stur;
  assign use_rb = is_rtype | is_stur | is_cbz;
  assign rb     = is_rtype ? rm : rt;

  assign hazard = held_valid_reg & last_load_valid_reg &
                  ((use_rn & (rn != XZR) & (rn == last_load_rt_reg)) |
                   (use_rb & (rb != XZR) & (rb == last_load_rt_reg)));

  assign issue_valid       = held_valid_reg & ~hazard & ~branch_flush;
  assign fire              = issue_valid & issue_ready;
  assign fetch_ready       = ~branch_flush & ~hazard & (~held_valid_reg | fire);
  assign issue_instruction = issue_valid ? held_instr_reg : '0;
  assign state             = state_reg;
  assign stall_count       = stall_count_reg;
  assign flush_count       = flush_count_reg;

  always_comb begin
    state_next           = state_reg;
    held_valid_next      = held_valid_reg;
    held_instr_next      = held_instr_reg;
    last_load_valid_next = last_load_valid_reg;
    last_load_rt_next    = last_load_rt_reg;
    stall_count_next     = stall_count_reg;
    flush_count_next     = flush_count_reg;

    if (branch_flush) begin
      held_valid_next      = 1'b0;
      last_load_valid_next = 1'b0;
      state_next           = EMPTY;
      if (held_valid_reg && (flush_count_reg != {CNT_W{1'b1}}))
        flush_count_next = flush_count_reg + CNT_W'(1);
    end else if (hazard) begin
      state_next = STALL;
      // A bubble only counts when downstream would otherwise have taken it.
      if (issue_ready) begin
        last_load_valid_next = 1'b0;
        last_load_rt_next    = rt;
        if (stall_count_reg != {CNT_W{1'b1}})
          stall_count_next = stall_count_reg + CNT_W'(1);
      end
    end else begin
      if (fetch_valid && fetch_ready) begin
        held_valid_next = 1'b1;
        held_instr_next = fetch_instruction;
      end else if (fire) begin
        held_valid_next = 1'b0;
      end
      if (issue_ready) begin
        last_load_valid_next = fire & is_ldur & (rt != XZR);
        last_load_rt_next    = rt;
      end
      state_next = held_valid_next ? FULL : EMPTY;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg           <= EMPTY;
      held_valid_reg      <= 1'b0;
      held_instr_reg      <= '0;
      last_load_valid_reg <= 1'b0;
      last_load_rt_reg    <= '0;
      stall_count_reg     <= '0;
      flush_count_reg     <= '0;
    end else begin
      state_reg           <= state_next;
      held_valid_reg      <= held_valid_next;
      held_instr_reg      <= held_instr_next;
      last_load_valid_reg <= last_load_valid_next;
      last_load_rt_reg    <= last_load_rt_next;
      stall_count_reg     <= stall_count_next;
      flush_count_reg     <= flush_count_next;
    end
  end

endmodule

// File: tb/tb_decode_issue_controller.sv
// Directed bench for decode_issue_controller: table of per-cycle vectors plus
// hand-written reset-during-stall and counter-saturation sequences.
module tb_decode_issue_controller;

  localparam logic [31:0] LD9  = 32'hF84402C9;
  localparam logic [31:0] ADD  = 32'h8B09026A;
  localparam logic [31:0] SUB  = 32'hCB0A028B;
  localparam logic [31:0] LDZ  = 32'hF84402DF;
  localparam logic [31:0] ADDZ = 32'h8B1F026A;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_valid;
  logic [31:0] fetch_instruction;
  logic        fetch_ready;
  logic        issue_valid;
  logic [31:0] issue_instruction;
  logic        issue_ready;
  logic        branch_flush;
  logic [1:0]  state;
  logic [15:0] stall_count;
  logic [15:0] flush_count;

  logic        s_fetch_ready, s_issue_valid;
  logic [31:0] s_issue_instruction;
  logic [1:0]  s_state;
  logic [1:0]  s_stall_count, s_flush_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  decode_issue_controller dut (
    .clk(clk), .rst(rst),
    .fetch_valid(fetch_valid), .fetch_instruction(fetch_instruction),
    .fetch_ready(fetch_ready), .issue_valid(issue_valid),
    .issue_instruction(issue_instruction), .issue_ready(issue_ready),
    .branch_flush(branch_flush), .state(state),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  // Narrow-counter copy so saturation is reachable in a short run.
  decode_issue_controller #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst),
    .fetch_valid(fetch_valid), .fetch_instruction(fetch_instruction),
    .fetch_ready(s_fetch_ready), .issue_valid(s_issue_valid),
    .issue_instruction(s_issue_instruction), .issue_ready(issue_ready),
    .branch_flush(branch_flush), .state(s_state),
    .stall_count(s_stall_count), .flush_count(s_flush_count)
  );

  typedef struct {
    logic        fv;
    logic [31:0] fi;
    logic        rdy;
    logic        bf;
    logic        e_iv;
    logic [31:0] e_ii;
    logic        e_fr;
    logic [1:0]  e_st;
    logic [15:0] e_sc;
    logic [15:0] e_fc;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic add(input logic fv, input logic [31:0] fi, input logic rdy, input logic bf,
                     input logic iv, input logic [31:0] ii, input logic fr, input logic [1:0] st,
                     input logic [15:0] sc, input logic [15:0] fc);
    vecs.push_back('{fv, fi, rdy, bf, iv, ii, fr, st, sc, fc});
  endtask

  task automatic drive(input logic fv, input logic [31:0] fi, input logic rdy, input logic bf);
    @(posedge clk);
    #1;
    fetch_valid       = fv;
    fetch_instruction = fi;
    issue_ready       = rdy;
    branch_flush      = bf;
  endtask

  initial begin
    rst = 1'b1; fetch_valid = 1'b0; fetch_instruction = '0;
    issue_ready = 1'b1; branch_flush = 1'b0;

    //   fv fi    rdy bf | iv ii    fr st sc fc
    add(0, 0,    1, 0,   0, 0,    1, 0, 0, 0); // reset state
    add(1, LD9,  1, 0,   0, 0,    1, 0, 0, 0);
    add(1, ADD,  1, 0,   1, LD9,  1, 1, 0, 0);
    add(1, SUB,  1, 0,   0, 0,    0, 1, 0, 0); // load-use bubble
    add(1, SUB,  1, 0,   1, ADD,  1, 2, 1, 0);
    add(0, 0,    1, 0,   1, SUB,  1, 1, 1, 0);
    add(1, LD9,  1, 0,   0, 0,    1, 0, 1, 0);
    add(1, SUB,  1, 0,   1, LD9,  1, 1, 1, 0);
    add(1, LDZ,  1, 0,   1, SUB,  1, 1, 1, 0); // independent: no bubble
    add(1, ADDZ, 1, 0,   1, LDZ,  1, 1, 1, 0);
    add(1, SUB,  1, 0,   1, ADDZ, 1, 1, 1, 0); // XZR: no bubble
    add(1, ADD,  1, 1,   0, 0,    0, 1, 1, 0); // flush held SUB
    add(0, 0,    1, 0,   0, 0,    1, 0, 1, 1); // offered ADD dropped
    add(1, SUB,  1, 0,   0, 0,    1, 0, 1, 1);
    add(1, LD9,  0, 0,   1, SUB,  0, 1, 1, 1); // backpressure x3
    add(1, LD9,  0, 0,   1, SUB,  0, 1, 1, 1);
    add(1, LD9,  0, 0,   1, SUB,  0, 1, 1, 1);
    add(0, 0,    1, 0,   1, SUB,  1, 1, 1, 1);
    add(0, 0,    1, 0,   0, 0,    1, 0, 1, 1);
    add(0, 0,    1, 1,   0, 0,    0, 0, 1, 1); // flush while empty
    add(0, 0,    1, 0,   0, 0,    1, 0, 1, 1);
    add(1, LD9,  1, 0,   0, 0,    1, 0, 1, 1);
    add(1, ADD,  1, 0,   1, LD9,  1, 1, 1, 1);
    add(0, 0,    1, 1,   0, 0,    0, 1, 1, 1); // hazard + flush
    add(0, 0,    1, 0,   0, 0,    1, 0, 1, 2);

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].fv, vecs[i].fi, vecs[i].rdy, vecs[i].bf);
      @(negedge clk);
      $display("vec %0d: fv=%b fi=%h rdy=%b bf=%b -> iv=%b ii=%h fr=%b st=%b sc=%0d fc=%0d",
               i, vecs[i].fv, vecs[i].fi, vecs[i].rdy, vecs[i].bf, issue_valid,
               issue_instruction, fetch_ready, state, stall_count, flush_count);
      check($sformatf("v%0d issue_valid", i), 32'(issue_valid), 32'(vecs[i].e_iv));
      check($sformatf("v%0d issue_instruction", i), issue_instruction, vecs[i].e_ii);
      check($sformatf("v%0d fetch_ready", i), 32'(fetch_ready), 32'(vecs[i].e_fr));
      check($sformatf("v%0d state", i), 32'(state), 32'(vecs[i].e_st));
      check($sformatf("v%0d stall_count", i), 32'(stall_count), 32'(vecs[i].e_sc));
      check($sformatf("v%0d flush_count", i), 32'(flush_count), 32'(vecs[i].e_fc));
    end

    // Reset asserted asynchronously while a hazard is parked in STALL.
    drive(1, LD9, 1, 0);
    drive(1, ADD, 1, 0);
    drive(0, 0, 0, 0);
    @(posedge clk);
    #1;
    check("stall state", 32'(state), 32'd2);
    check("stall issue_valid", 32'(issue_valid), 32'd0);
    check("stall fetch_ready", 32'(fetch_ready), 32'd0);
    check("stall stall_count", 32'(stall_count), 32'd1);
    #2 rst = 1'b1;
    #1;
    $display("async reset mid-stall: iv=%b ii=%h fr=%b st=%b sc=%0d fc=%0d",
             issue_valid, issue_instruction, fetch_ready, state, stall_count, flush_count);
    check("rst issue_valid", 32'(issue_valid), 32'd0);
    check("rst issue_instruction", issue_instruction, 32'd0);
    check("rst fetch_ready", 32'(fetch_ready), 32'd1);
    check("rst state", 32'(state), 32'd0);
    check("rst stall_count", 32'(stall_count), 32'd0);
    check("rst flush_count", 32'(flush_count), 32'd0);
    #1 rst = 1'b0;

    // Four squashes of a held instruction: 2-bit counter must stop at 3.
    for (int k = 0; k < 4; k++) begin
      drive(1, SUB, 1, 0);
      drive(0, 0, 1, 1);
      drive(0, 0, 1, 0);
    end
    @(negedge clk);
    $display("saturation: flush_count=%0d narrow flush_count=%0d", flush_count, s_flush_count);
    check("sat flush_count wide", 32'(flush_count), 32'd4);
    check("sat flush_count narrow", 32'(s_flush_count), 32'd3);
    check("sat stall_count narrow", 32'(s_stall_count), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
